// File: rtl/adc_status_pio_pkg.sv
// rtl/adc_status_pio_pkg.sv - register addresses and edge-type encodings for the ADC status PIO
package adc_status_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   function automatic logic edge_hit(input int edge_type, input logic cur, input logic prev);
      case (edge_type)
         EDGE_RISE: return cur & ~prev;
         EDGE_FALL: return ~cur & prev;
         default:   return cur ^ prev;
      endcase
   endfunction

endpackage

// File: rtl/pio_in_condition_bit.sv
// rtl/pio_in_condition_bit.sv - per-bit synchroniser, optional debounce and edge detect
module pio_in_condition_bit
   import adc_status_pio_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = EDGE_RISE
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_bit,
   output logic stable,
   output logic detected
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
   end

   assign s = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
         assign stable = s;
      end else begin : g_debounce
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         logic [CW-1:0] cnt_q;
         logic          stable_q;

         // s must disagree with stable on N consecutive edges before it is accepted
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q    <= '0;
               stable_q <= 1'b0;
            end else if (s == stable_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
               stable_q <= s;
               cnt_q    <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         assign stable = stable_q;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev_q <= 1'b0;
      else          prev_q <= stable;
   end

   assign detected = edge_hit(EDGE_TYPE, stable, prev_q);

endmodule

// File: rtl/adc_status_pio_irq.sv
// rtl/adc_status_pio_irq.sv - Avalon-MM ADC status input port with edge capture and masked IRQ
module adc_status_pio_irq
   import adc_status_pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] stable_vec;
   logic [WIDTH-1:0] detected_vec;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] ec_clr;
   logic [31:0]      rd_next;
   logic             wr_en;
   logic             unused_wd;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         pio_in_condition_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .EDGE_TYPE       (EDGE_TYPE)
         ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_bit   (in_port[i]),
            .stable   (stable_vec[i]),
            .detected (detected_vec[i])
         );
      end
   endgenerate

   assign wr_en     = chipselect & ~write_n;
   assign ec_clr    = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
   assign unused_wd = ^writedata;

   // a new edge in the same cycle as a clear keeps the bit set
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask     <= '0;
         edgecapture <= '0;
      end else begin
         if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
         edgecapture <= (edgecapture & ~ec_clr) | detected_vec;
      end
   end

   always_comb begin
      rd_next = '0;
      case (address)
         ADDR_DATA:    rd_next = 32'(stable_vec);
         ADDR_RSVD:    rd_next = '0;
         ADDR_IRQMASK: rd_next = 32'(irqmask);
         ADDR_EDGECAP: rd_next = 32'(edgecapture);
         default:      rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_next;
   end

   assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_adc_status_pio_irq.sv
// tb/tb_adc_status_pio_irq.sv - directed self-checking bench for adc_status_pio_irq
module tb_adc_status_pio_irq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        write_n;
   logic [31:0] writedata;
   logic        cs0, cs1, cs2;
   logic [31:0] rd0, rd1, rd2;
   logic [3:0]  in0, in1, in2;
   logic        irq0, irq1, irq2;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   adc_status_pio_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0), .write_n(write_n),
      .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0));

   adc_status_pio_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) u_fall (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1), .write_n(write_n),
      .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1));

   adc_status_pio_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2), .write_n(write_n),
      .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write_n   = 1'b0;
      cs0 = (sel == 0);
      cs1 = (sel == 1);
      cs2 = (sel == 2);
      tick();
      write_n = 1'b1;
      cs0 = 1'b0;
      cs1 = 1'b0;
      cs2 = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a);
      address = a;
      tick();
   endtask

   initial begin
      reset_n = 1'b0; address = 2'd0; write_n = 1'b1; writedata = '0;
      cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
      in0 = 4'h0; in1 = 4'h0; in2 = 4'h0;
      repeat (3) @(negedge clk);
      chk("reset_irq0", {31'b0, irq0}, 32'h0);
      chk("reset_rd0", rd0, 32'h0);
      reset_n = 1'b1;
      tick(3);

      rd(2'd0); chk("init_data", rd0, 32'h0);
      rd(2'd1); chk("init_rsvd", rd0, 32'h0);
      rd(2'd2); chk("init_mask", rd0, 32'h0);
      rd(2'd3); chk("init_ecap", rd0, 32'h0);
      chk("init_irq", {31'b0, irq0}, 32'h0);
      wr(0, 2'd2, 32'hFFFF_FFFF);
      rd(2'd2); chk("mask_wr_F", rd0, 32'h0000_000F);
      wr(0, 2'd1, 32'h5);
      rd(2'd1); chk("rsvd_wr_ignored", rd0, 32'h0);
      wr(0, 2'd2, 32'h1);

      // rising edge on bit 0, N=0: capture and irq at e2
      address = 2'd0;
      in0 = 4'b0001;
      tick(2);
      chk("rise_irq_e1", {31'b0, irq0}, 32'h0);
      tick();
      chk("rise_irq_e2", {31'b0, irq0}, 32'h1);
      chk("rise_data_e2", rd0, 32'h1);
      rd(2'd3); chk("rise_ecap", rd0, 32'h1);
      wr(0, 2'd0, 32'h0);
      rd(2'd0); chk("data_wr_ignored", rd0, 32'h1);
      wr(0, 2'd3, 32'h1);
      chk("w1c_irq", {31'b0, irq0}, 32'h0);
      rd(2'd3); chk("w1c_ecap", rd0, 32'h0);

      // falling-edge instance
      in1 = 4'b0100;
      tick(4);
      rd(2'd3); chk("fall_rise_nocap", rd1, 32'h0);
      in1 = 4'b0000;
      tick(4);
      rd(2'd3); chk("fall_cap", rd1, 32'h4);
      chk("fall_mask0_irq", {31'b0, irq1}, 32'h0);
      wr(1, 2'd2, 32'h4);
      chk("fall_mask4_irq", {31'b0, irq1}, 32'h1);

      // debounce N=4: 3-cycle glitch rejected
      in2 = 4'b0010;
      tick(3);
      in2 = 4'b0000;
      tick(8);
      rd(2'd0); chk("glitch_data", rd2, 32'h0);
      rd(2'd3); chk("glitch_ecap", rd2, 32'h0);
      address = 2'd0;
      in2 = 4'b0010;
      tick(6);
      chk("deb_data_e5", rd2, 32'h0);
      tick();
      chk("deb_data_e6", rd2, 32'h2);
      rd(2'd3); chk("deb_ecap", rd2, 32'h2);

      // any-edge capture racing a W1C of the same bit
      in2 = 4'b1010;
      tick(10);
      rd(2'd3); chk("any_ecap_pre", rd2, 32'hA);
      wr(2, 2'd3, 32'hF);
      rd(2'd3); chk("any_clear_all", rd2, 32'h0);
      in2 = 4'b0010;
      tick(6);
      wr(2, 2'd3, 32'h8);
      rd(2'd3); chk("set_wins_w1c", rd2, 32'h8);
      wr(2, 2'd3, 32'h0);
      rd(2'd3); chk("w1c_zero", rd2, 32'h8);
      chk("any_irq_unmasked", {31'b0, irq2}, 32'h0);

      // asynchronous reset mid-debounce with captures pending
      wr(0, 2'd2, 32'h3);
      in0 = 4'b0011;
      tick(3);
      chk("pre_reset_irq0", {31'b0, irq0}, 32'h1);
      chk("pre_reset_irq1", {31'b0, irq1}, 32'h1);
      in2 = 4'b0000;
      address = 2'd3;
      tick(2);
      #2 reset_n = 1'b0;
      #1;
      chk("areset_irq0", {31'b0, irq0}, 32'h0);
      chk("areset_irq1", {31'b0, irq1}, 32'h0);
      chk("areset_rd2", rd2, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick(4);
      rd(2'd3); chk("post_reset_ecap0", rd0, 32'h3);
      chk("post_reset_ecap2", rd2, 32'h0);
      chk("post_reset_irq0", {31'b0, irq0}, 32'h0);
      rd(2'd2); chk("post_reset_mask1", rd1, 32'h0);
      rd(2'd0); chk("post_reset_data2", rd2, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
